// File: rtl/speed_test_sequencer.sv
// speed_test_sequencer: runs N timed tests on a masked set of generator/checker
// pairs, driven by a command word in a shared 64-bit control memory.
// Optional: define SPEED_TEST_ABORT_EN so the host can end a run early by
// clearing go in the command word while the run is in progress.
//
// state      | meaning
// IDLE       | poll command word (addr 0) for go
// LOAD       | read config words of enabled ports, one per cycle
// LOAD_STAT  | write status word (testing)
// WAIT_READY | wait until all enabled generators and checkers are ready
// START      | one-cycle start pulse on enabled ports
// RUN        | count the test duration
// STOP       | one-cycle stop pulse on enabled ports
// DRAIN      | wait until all enabled checkers are idle
// WRITEBACK  | store each enabled port's result for this run
// FIN_STAT   | write final status word
// FIN_CMD    | write command word back with go cleared
module speed_test_sequencer #(
  parameter int MEM_ADDR_WIDTH = 9,
  parameter int TEST_PORT      = 4,
  parameter int MAX_RUNS       = 8,
  parameter int CFG_BASE       = 8,
  parameter int RES_BASE       = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [63:0]               mem_din,
  input  logic [63:0]               mem_dout,
  input  logic [TEST_PORT-1:0]      gen_ready,
  input  logic [TEST_PORT-1:0]      check_ready,
  input  logic [TEST_PORT*64-1:0]   check_results,
  output logic [TEST_PORT-1:0]      start,
  output logic [TEST_PORT-1:0]      stop,
  output logic [TEST_PORT*64-1:0]   port_config
);

  localparam int PW = (TEST_PORT > 1) ? $clog2(TEST_PORT) : 1;
  localparam logic [7:0]  REP_MAX  = 8'(MAX_RUNS);
  localparam logic [31:0] TMO_LOAD = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, LOAD_STAT, WAIT_READY, START, RUN, STOP, DRAIN,
    WRITEBACK, FIN_STAT, FIN_CMD
  } state_t;

  state_t                state_q, state_d;
  logic [63:1]           cmd_hi_q;
  logic [TEST_PORT-1:0]  mask_q;
  logic [7:0]            rep_q;
  logic [7:0]            runs_q;
  logic [31:0]           dur_q;
  logic [31:0]           tmr_q;
  logic [TEST_PORT-1:0]  pend_q;
  logic                  rd_cmd_q;
  logic                  rd_pend_q;
  logic [PW-1:0]         rd_port_q;
  logic                  f_timeout, f_empty, f_abort;

  logic [TEST_PORT-1:0]  cmd_mask;
  logic [7:0]            cmd_rep;
  logic [31:0]           cmd_dur;
  logic [PW-1:0]         low_idx;
  logic [TEST_PORT-1:0]  pend_rest;
  logic                  cmd_rd;
  logic                  timeout_ev;
  logic                  abort_ev;
  logic [13:0]           status_hi;

  // Decode and clamp the command word as it arrives from memory.
  always_comb begin
    cmd_mask = mem_dout[8 +: TEST_PORT];
    cmd_rep  = mem_dout[23:16];
    if (cmd_rep == 8'd0)
      cmd_rep = 8'd1;
    else if (cmd_rep > REP_MAX)
      cmd_rep = REP_MAX;
    cmd_dur = mem_dout[55:24];
    if (cmd_dur == 32'd0)
      cmd_dur = 32'd1;
  end

  // Lowest pending port; LOAD and WRITEBACK walk the mask in ascending order.
  always_comb begin
    low_idx = '0;
    for (int i = TEST_PORT - 1; i >= 0; i--)
      if (pend_q[i]) low_idx = PW'(i);
    pend_rest = pend_q & (pend_q - TEST_PORT'(1));
  end

  assign status_hi = {runs_q, 3'd0, f_abort, f_empty, f_timeout};

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;
    start      = '0;
    stop       = '0;
    cmd_rd     = 1'b0;
    timeout_ev = 1'b0;
    abort_ev   = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_rd = 1'b1;
        if (rd_cmd_q && mem_dout[0])
          state_d = (cmd_mask == '0) ? FIN_STAT : LOAD;
      end
      LOAD: begin
        mem_addr = MEM_ADDR_WIDTH'(CFG_BASE + int'(low_idx));
        if (pend_rest == '0) state_d = LOAD_STAT;
      end
      LOAD_STAT: begin
        mem_we   = 1'b1;
        mem_addr = MEM_ADDR_WIDTH'(1);
        mem_din  = {48'd0, status_hi, 2'd1};
        state_d  = WAIT_READY;
      end
      WAIT_READY: begin
        if ((gen_ready & check_ready & mask_q) == mask_q)
          state_d = START;
        else if (tmr_q == 32'd0) begin
          timeout_ev = 1'b1;
          state_d    = FIN_STAT;
        end
      end
      START: begin
        start   = mask_q;
        state_d = RUN;
      end
      RUN: begin
`ifdef SPEED_TEST_ABORT_EN
        cmd_rd = 1'b1;
        if (rd_cmd_q && !mem_dout[0]) begin
          abort_ev = 1'b1;
          state_d  = STOP;
        end
`endif
        if (tmr_q == 32'd1) state_d = STOP;
      end
      STOP: begin
        stop    = mask_q;
        state_d = DRAIN;
      end
      DRAIN: begin
        if ((check_ready & mask_q) == mask_q)
          state_d = WRITEBACK;
        else if (tmr_q == 32'd0) begin
          timeout_ev = 1'b1;
          state_d    = FIN_STAT;
        end
      end
      WRITEBACK: begin
        mem_we   = 1'b1;
        mem_addr = MEM_ADDR_WIDTH'(RES_BASE + int'(runs_q) * TEST_PORT + int'(low_idx));
        mem_din  = check_results[int'(low_idx)*64 +: 64];
        if (pend_rest == '0)
          state_d = (f_abort || ((runs_q + 8'd1) >= rep_q)) ? FIN_STAT : WAIT_READY;
      end
      FIN_STAT: begin
        mem_we   = 1'b1;
        mem_addr = MEM_ADDR_WIDTH'(1);
        mem_din  = {48'd0, status_hi, 2'd2};
        state_d  = FIN_CMD;
      end
      FIN_CMD: begin
        mem_we   = 1'b1;
        mem_addr = '0;
        mem_din  = {cmd_hi_q, 1'b0};
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, command latch, timers, counters and config capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_hi_q    <= '0;
      mask_q      <= '0;
      rep_q       <= '0;
      runs_q      <= '0;
      dur_q       <= '0;
      tmr_q       <= '0;
      pend_q      <= '0;
      rd_cmd_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_port_q   <= '0;
      f_timeout   <= 1'b0;
      f_empty     <= 1'b0;
      f_abort     <= 1'b0;
      port_config <= '0;
    end else begin
      state_q   <= state_d;
      rd_cmd_q  <= cmd_rd;
      rd_pend_q <= (state_q == LOAD);
      rd_port_q <= low_idx;
      if (rd_pend_q)
        port_config[int'(rd_port_q)*64 +: 64] <= mem_dout;

      if (state_q == IDLE && state_d != IDLE) begin
        cmd_hi_q  <= mem_dout[63:1];
        mask_q    <= cmd_mask;
        rep_q     <= cmd_rep;
        dur_q     <= cmd_dur;
        runs_q    <= '0;
        pend_q    <= cmd_mask;
        f_timeout <= 1'b0;
        f_abort   <= 1'b0;
        f_empty   <= (cmd_mask == '0);
      end

      if (state_q == LOAD || state_q == WRITEBACK)
        pend_q <= pend_rest;
      if (state_q == DRAIN && state_d == WRITEBACK)
        pend_q <= mask_q;
      if (state_q == WRITEBACK && state_d != WRITEBACK)
        runs_q <= runs_q + 8'd1;

      // One shared down-counter: ready/drain bound, or run duration.
      if ((state_d == WAIT_READY || state_d == DRAIN) && state_d != state_q)
        tmr_q <= TMO_LOAD;
      else if (state_q == START)
        tmr_q <= dur_q;
      else if (tmr_q != 32'd0)
        tmr_q <= tmr_q - 32'd1;

      if (timeout_ev) f_timeout <= 1'b1;
      if (abort_ev)   f_abort   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_speed_test_sequencer.sv
// Bench for speed_test_sequencer: transaction-level model of the expected
// memory writes and start/stop pulses, checked every cycle by a monitor.
module tb_speed_test_sequencer;
  localparam int AW = 9;
  localparam int NP = 4;
  localparam int TO = 1000;

  localparam int SC_NORMAL = 0;
  localparam int SC_RDY_TO = 1;
  localparam int SC_DRN_TO = 2;
  localparam int SC_ABORT  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [63:0]       mem_din;
  logic [63:0]       mem_dout = 64'd0;
  logic [NP-1:0]     gen_ready = '1;
  logic [NP-1:0]     check_ready;
  logic [NP*64-1:0]  check_results;
  logic [NP-1:0]     start, stop;
  logic [NP*64-1:0]  port_config;

  speed_test_sequencer #(
    .MEM_ADDR_WIDTH(AW), .TEST_PORT(NP), .MAX_RUNS(8),
    .CFG_BASE(8), .RES_BASE(16), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .gen_ready(gen_ready),
    .check_ready(check_ready), .check_results(check_results),
    .start(start), .stop(stop), .port_config(port_config)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Control memory with a host write port used by the bench.
  logic [63:0]   mem [0:(1<<AW)-1] = '{default: 64'd0};
  logic          host_we = 1'b0;
  logic [AW-1:0] host_a = '0;
  logic [63:0]   host_d = 64'd0;
  always @(posedge clk) begin
    if (host_we) mem[host_a] = host_d;
    if (mem_we) mem[mem_addr] = mem_din;
    else mem_dout <= mem[mem_addr];
  end

  typedef struct { logic [AW-1:0] a; logic [63:0] d; } wr_t;
  wr_t exp_arr[$];

  // driver-owned expectations
  int          tid = 0;
  int          scen = SC_NORMAL;
  logic [NP-1:0] exp_mask = '0;
  longint      exp_dur = 1;
  int          clr_cyc = 0;
  logic [63:0] exp_cfg [NP] = '{default: 64'd0};

  // monitor-owned state
  int   exp_rd = 0;
  int   n_start = 0, n_stop = 0, run_tag = 0;
  int   start_cyc = 0, stop_cyc = 0, load_cyc = 0, fin_cyc = 0;
  logic drop0 = 1'b0;

  function automatic logic [63:0] res_word(input int r, input int p);
    return 64'hC0DE_0000_0000_0000 | (64'(r) << 8) | 64'(p);
  endfunction

  function automatic logic [63:0] cfg_word(input int t, input int p);
    return 64'hCF60_0000_0000_0000 | (64'(t) << 8) | 64'(p);
  endfunction

  function automatic logic [63:0] mk_cmd(input logic [7:0] m, input logic [7:0] rep, input logic [31:0] dur);
    return {8'hA5, dur, rep, m, 7'd0, 1'b1};
  endfunction

  always_comb begin
    check_ready = {{(NP-1){1'b1}}, ~drop0};
    for (int p = 0; p < NP; p++) check_results[p*64 +: 64] = res_word(run_tag, p);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: checks every pulse and every memory write against the model.
  initial begin
    int last_id;
    wr_t w;
    last_id = -1;
    forever begin
      @(negedge clk);
      if (tid != last_id) begin
        last_id = tid; exp_rd = 0; n_start = 0; n_stop = 0; run_tag = 0; drop0 = 1'b0;
      end
      if (!rst) begin
        if (start != '0 || stop != '0) chk("pulse_excl", 64'(start & stop), 64'd0);
        if (start != '0) begin
          chk("start_mask", 64'(start), 64'(exp_mask));
          n_start++;
          start_cyc = cyc;
        end
        if (stop != '0) begin
          chk("stop_mask", 64'(stop), 64'(exp_mask));
          n_stop++;
          stop_cyc = cyc;
          if (scen == SC_ABORT) chk_range("abort_stop_latency", cyc - clr_cyc, 1, 2);
          else chk("stop_gap", 64'(cyc - start_cyc), 64'(exp_dur + 1));
          run_tag++;
          if (scen == SC_DRN_TO) drop0 = 1'b1;
        end
        if (mem_we) begin
          if (exp_rd >= exp_arr.size()) begin
            tests++; fails++;
            $display("FAIL unexpected_write: got addr %0d data %h expected none", mem_addr, mem_din);
          end else begin
            w = exp_arr[exp_rd];
            exp_rd++;
            chk("wr_addr", 64'(mem_addr), 64'(w.a));
            chk("wr_data", mem_din, w.d);
            if (w.a == 1 && w.d[1:0] == 2'd1) load_cyc = cyc;
            if (w.a == 1 && w.d[1:0] == 2'd2) fin_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic host_write(input int a, input logic [63:0] d);
    host_we = 1'b1; host_a = AW'(a); host_d = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic push(input int a, input logic [63:0] d);
    wr_t w;
    w.a = AW'(a); w.d = d;
    exp_arr.push_back(w);
  endtask

  task automatic run_test(input logic [63:0] cmd, input int sc, input logic [NP-1:0] gready);
    logic [NP-1:0] m;
    int rep, runs, ex_starts;
    longint dur;
    logic [63:0] st;
    bit done;
    @(negedge clk);
    for (int p = 0; p < NP; p++) host_write(8 + p, cfg_word(tid + 1, p));
    m = cmd[8 +: NP];
    rep = int'(cmd[23:16]);
    if (rep == 0) rep = 1;
    if (rep > 8) rep = 8;
    dur = longint'(cmd[55:24]);
    if (dur == 0) dur = 1;
    if (m == '0) runs = 0;
    else if (sc == SC_NORMAL) runs = rep;
    else if (sc == SC_ABORT) runs = 1;
    else runs = 0;
    ex_starts = (m == '0 || sc == SC_RDY_TO) ? 0 : (sc == SC_NORMAL ? rep : 1);
    exp_arr.delete();
    if (m != '0) push(1, 64'h1);
    for (int r = 0; r < runs; r++)
      for (int p = 0; p < NP; p++)
        if (m[p]) push(16 + r * NP + p, res_word(r + 1, p));
    st = (64'(runs) << 8) | 64'h2;
    if (sc == SC_ABORT) st |= 64'h10;
    if (m == '0) st |= 64'h8;
    if (sc == SC_RDY_TO || sc == SC_DRN_TO) st |= 64'h4;
    push(1, st);
    push(0, cmd & ~64'd1);
    if (m != '0)
      for (int p = 0; p < NP; p++) if (m[p]) exp_cfg[p] = cfg_word(tid + 1, p);
    scen = sc; exp_mask = m; exp_dur = dur; gen_ready = gready;
    tid++;
    host_write(0, cmd);
    if (sc == SC_ABORT) begin
      for (int i = 0; i < 500 && n_start == 0; i++) @(negedge clk);
      repeat (200) @(negedge clk);
      clr_cyc = cyc;
      host_write(0, cmd & ~64'd1);
    end
    done = 0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      done = (exp_rd == exp_arr.size());
    end
    chk("all_writes_seen", 64'(exp_rd), 64'(exp_arr.size()));
    repeat (3) @(negedge clk);
    chk("start_count", 64'(n_start), 64'(ex_starts));
    chk("stop_count", 64'(n_stop), 64'(ex_starts));
    for (int p = 0; p < NP; p++) chk("port_config", port_config[p*64 +: 64], exp_cfg[p]);
    gen_ready = '1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] c;
    repeat (3) @(negedge clk);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_start_stop", 64'({start, stop}), 64'd0);
    chk("rst_port_config", 64'(|port_config), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_test(mk_cmd(8'h05, 8'd1, 32'd100), SC_NORMAL, '1);
    chk("t1_status", mem[1], 64'h0102);
    chk("t1_res_p0", mem[16], 64'hC0DE_0000_0000_0100);
    chk("t1_res_p2", mem[18], 64'hC0DE_0000_0000_0102);
    chk("t1_go_cleared", 64'(mem[0][0]), 64'd0);
    chk("t1_cfg_p0", port_config[63:0], 64'hCF60_0000_0000_0100);
    chk("t1_cfg_p1_untouched", port_config[127:64], 64'd0);

    run_test(mk_cmd(8'h0F, 8'd3, 32'd10), SC_NORMAL, '1);
    chk("t2_status", mem[1], 64'h0302);
    chk("t2_res_last", mem[27], 64'hC0DE_0000_0000_0303);

    run_test(mk_cmd(8'hF0, 8'd2, 32'd10), SC_NORMAL, '1);
    chk("t3_empty_status", mem[1], 64'h000A);

    run_test(mk_cmd(8'h02, 8'd1, 32'd10), SC_RDY_TO, 4'b1101);
    chk("t4_ready_to_status", mem[1], 64'h0006);
    chk_range("t4_ready_to_gap", fin_cyc - load_cyc, TO, TO + 3);

    run_test(mk_cmd(8'h01, 8'd1, 32'd10), SC_DRN_TO, '1);
    chk("t5_drain_to_status", mem[1], 64'h0006);
    chk_range("t5_drain_to_gap", fin_cyc - stop_cyc, TO, TO + 3);

    run_test(mk_cmd(8'h09, 8'd20, 32'd0), SC_NORMAL, '1);
    chk("t6_clamp_status", mem[1], 64'h0802);
    chk("t6_res_last", mem[47], 64'hC0DE_0000_0000_0803);

    run_test(mk_cmd(8'h02, 8'd0, 32'd3), SC_NORMAL, '1);
    chk("t7_rep0_status", mem[1], 64'h0102);

`ifdef SPEED_TEST_ABORT_EN
    run_test(mk_cmd(8'h03, 8'd3, 32'd1000), SC_ABORT, '1);
    chk("t8_abort_status", mem[1], 64'h0112);
`endif

    // Reset in the middle of a run.
    @(negedge clk);
    c = mk_cmd(8'h01, 8'd1, 32'd1000);
    exp_arr.delete();
    push(1, 64'h1);
    scen = SC_NORMAL; exp_mask = 4'h1; exp_dur = 1000;
    tid++;
    host_write(0, c);
    for (int i = 0; i < 500 && n_start == 0; i++) @(negedge clk);
    chk("t9_started", 64'(n_start), 64'd1);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    exp_arr.delete();
    tid++;
    host_write(0, 64'd0);
    chk("t9_rst_mem_we", 64'(mem_we), 64'd0);
    chk("t9_rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("t9_rst_pulses", 64'({start, stop}), 64'd0);
    chk("t9_rst_port_config", 64'(|port_config), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("t9_no_pulses_after_rst", 64'(n_start + n_stop), 64'd0);
    chk("t9_status_unchanged", mem[1], 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
